uart_time_tx: RTL and testbench
===============================

// Module: uart_time_tx
// PURPOSE
//  Serial transmitter that reports the running clock time to a host as an ASCII line "HH:MM\r\n".
//  8N1 UART, LSB first. Output direction of the user interface: buttons set the time, this block reports it.
//  Sits beside the clock-mode counters in top; fed by hourCountNum/minCountNum/secCountNum.
//  Triggered by a one-cycle request (e.g. minute roll-over or a debounced button pulse).
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200 baud); legal range >= 2
// PORTS
//  clk      in   1  system clock, all logic on rising edge
//  rst_btn  in   1  asynchronous, active-low reset
//  send     in   1  one-cycle request to transmit one time frame
//  hour     in   8  binary hours, 0..23 in normal use
//  min      in   8  binary minutes, 0..59 in normal use
//  sec      in   8  binary seconds; used only when TX_SECONDS_EN is defined
//  tx       out  1  UART serial line, idle high
//  busy     out  1  high from accepted send until the last stop bit completes
//  drop     out  1  one-cycle pulse when a send arrives while busy=1
// BEHAVIOUR
//  Reset (async, rst_btn=0): tx=1, busy=0, drop=0, FSM=IDLE, all counters 0, snapshot regs 0.
//  FSM: IDLE -> LOAD -> START -> DATA -> STOP -> (NEXT byte ? LOAD : IDLE).
//  IDLE: send=1 at edge k -> snapshot hour/min/sec, byte index=0, busy=1, state LOAD after edge k.
//  LOAD: fetch ASCII byte[idx] into shift reg. 1 cycle. tx falls (START) after edge k+1.
//  START/each DATA bit/STOP: held for exactly CLKS_PER_BIT cycles. Baud counter runs 0..CLKS_PER_BIT-1.
//  DATA: 8 bits, LSB first. STOP: tx=1.
//  End of STOP: if idx < last, idx++ and go to LOAD (1-cycle high gap before next start bit).
//  After the last byte's STOP: busy=0 and state=IDLE on the same edge.
//  Frame bytes: tens(hour), ones(hour), ':', tens(min), ones(min), 0x0D, 0x0A (7 bytes).
//  Digit rule: value v<=99 -> tens='0'+v/10, ones='0'+v%10.
//    v>=100 -> both digits '?' (0x3F). No other clamping: 24..99 are sent as-is.
//  Inputs are sampled only at acceptance. Changes to hour/min/sec mid-frame do not alter the frame.
//  send while busy=1: ignored, frame unaffected, drop=1 for that cycle.
//  send on the cycle busy is 0 (incl. the cycle right after busy falls) is accepted normally.
//  Reset mid-frame: tx returns high immediately (async). The partial byte is abandoned; no resume.
//  Frame duration: N bytes * (1 + 10*CLKS_PER_BIT) cycles from accept edge to busy falling.
// CONFIGURATION
//  Macro TX_SECONDS_EN.
//    Defined: the frame is "HH:MM:SS\r\n" (10 bytes), with sec digits using the same digit rule.
//    Undefined: the frame is the 7-byte "HH:MM\r\n"; the sec port is present but unused.
//  Byte-index width sizes to the frame length in both builds.
// STRUCTURE
//  Shared package/include (clock_pkg):
//    ASCII constants CH_ZERO=0x30, CH_COLON=0x3A, CH_CR=0x0D, CH_LF=0x0A, CH_UNK=0x3F.
//    FSM state encodings (IDLE, LOAD, START, DATA, STOP).
//    Frame-length constants FRAME_LEN_HM=7, FRAME_LEN_HMS=10.
//  Sub-module bin2ascii2: 8-bit binary in -> {tens,ones} ASCII out, applying the '?' rule.
//    Combinational; instantiated once per field.
//  Baud counter, bit counter, shift register and FSM stay in uart_time_tx.
// TESTING (bench uses CLKS_PER_BIT=4; a UART monitor samples mid-bit)
//  1. Reset, then hour=13, min=7, send pulse -> bytes 31 33 3A 30 37 0D 0A.
//     tx low 2 cycles after accept; busy high 7*41=287 cycles.
//  2. hour=0, min=59 -> "00:59\r\n". hour=120, min=5 -> 3F 3F 3A 30 35 0D 0A.
//  3. Mid-frame changes: after accept, change hour to 22 at byte 2 -> frame still carries the snapshot "13".
//     send pulses during busy -> drop=1 each time; no extra frame.
//  4. Back-to-back: send asserted the cycle after busy falls -> accepted; the second frame is identical in format.
//  5. Reset mid-frame: assert rst_btn low during DATA of byte 3 -> tx=1, busy=0 at once.
//     After release, a new send yields a complete, correct frame.
//  6. TX_SECONDS_EN defined: hour=9, min=30, sec=45 -> "09:30:45\r\n" (10 bytes, busy 410 cycles).

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the clock block: ASCII codes, UART transmitter FSM states, frame lengths.
package clock_pkg;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_UNK   = 8'h3F;

    localparam int FRAME_LEN_HM  = 7;
    localparam int FRAME_LEN_HMS = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } txState_t;

    typedef struct packed {
        logic [7:0] tens;
        logic [7:0] ones;
    } asciiPair_t;

endpackage

// File: rtl/bin2ascii2.sv
// Two-digit binary-to-ASCII converter; values above 99 become "??" rather than wrapping.
module bin2ascii2
    import clock_pkg::*;
(
    input  logic [7:0] bin,
    output asciiPair_t digits
);

    logic [7:0] tensVal;
    logic [7:0] onesVal;

    always_comb begin
        tensVal     = bin / 8'd10;
        onesVal     = bin % 8'd10;
        digits.tens = CH_UNK;
        digits.ones = CH_UNK;
        if (bin <= 8'd99) begin
            digits.tens = CH_ZERO + tensVal;
            digits.ones = CH_ZERO + onesVal;
        end
    end

endmodule

// File: rtl/uart_time_tx.sv
// 8N1 UART reporting the clock time as "HH:MM\r\n" on a one-cycle send request.
// Define TX_SECONDS_EN to extend the frame to "HH:MM:SS\r\n".
module uart_time_tx
    import clock_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic       send,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    output logic       tx,
    output logic       busy,
    output logic       drop
);

`ifdef TX_SECONDS_EN
    localparam int FRAME_LEN = FRAME_LEN_HMS;
`else
    localparam int FRAME_LEN = FRAME_LEN_HM;
`endif
    localparam int IDX_W  = $clog2(FRAME_LEN);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    txState_t          state;
    txState_t          nextState;
    logic [BAUD_W-1:0] baudCnt;
    logic [2:0]        bitCnt;
    logic [IDX_W-1:0]  byteIdx;
    logic [7:0]        shiftReg;
    logic [7:0]        hourSnap;
    logic [7:0]        minSnap;
    logic [7:0]        frameByte;
    logic              bitEnd;
    logic              bitTiming;
    asciiPair_t        hourAsc;
    asciiPair_t        minAsc;

    assign bitTiming = (state == START) || (state == DATA) || (state == STOP);
    assign bitEnd    = bitTiming && (baudCnt == BAUD_LAST);

    bin2ascii2 uHourAsc (.bin(hourSnap), .digits(hourAsc));
    bin2ascii2 uMinAsc  (.bin(minSnap),  .digits(minAsc));

`ifdef TX_SECONDS_EN
    logic [7:0] secSnap;
    asciiPair_t secAsc;

    bin2ascii2 uSecAsc (.bin(secSnap), .digits(secAsc));

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn)
            secSnap <= '0;
        else if (state == IDLE && send)
            secSnap <= sec;
    end
`else
    logic unusedSec;
    assign unusedSec = ^sec;
`endif

    always_comb begin
        frameByte = CH_LF;
        case (byteIdx)
            IDX_W'(0): frameByte = hourAsc.tens;
            IDX_W'(1): frameByte = hourAsc.ones;
            IDX_W'(2): frameByte = CH_COLON;
            IDX_W'(3): frameByte = minAsc.tens;
            IDX_W'(4): frameByte = minAsc.ones;
`ifdef TX_SECONDS_EN
            IDX_W'(5): frameByte = CH_COLON;
            IDX_W'(6): frameByte = secAsc.tens;
            IDX_W'(7): frameByte = secAsc.ones;
            IDX_W'(8): frameByte = CH_CR;
`else
            IDX_W'(5): frameByte = CH_CR;
`endif
            default:   frameByte = CH_LF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (send) nextState = LOAD;
            LOAD:    nextState = START;
            START:   if (bitEnd) nextState = DATA;
            DATA:    if (bitEnd && bitCnt == 3'd7) nextState = STOP;
            STOP:    if (bitEnd) nextState = (byteIdx == LAST_IDX) ? IDLE : LOAD;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state != IDLE);
        drop = send && busy;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shiftReg[0];
            default: tx = 1'b1;
        endcase
    end

    // The baud counter restarts on every bit boundary, so each bit is exactly CLKS_PER_BIT long.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            baudCnt  <= '0;
            bitCnt   <= '0;
            byteIdx  <= '0;
            shiftReg <= '0;
            hourSnap <= '0;
            minSnap  <= '0;
        end else begin
            baudCnt <= (bitTiming && !bitEnd) ? baudCnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (send) begin
                        hourSnap <= hour;
                        minSnap  <= min;
                        byteIdx  <= '0;
                    end
                end
                LOAD: begin
                    shiftReg <= frameByte;
                    bitCnt   <= '0;
                end
                DATA: begin
                    if (bitEnd) begin
                        shiftReg <= {1'b0, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bitEnd && byteIdx != LAST_IDX)
                        byteIdx <= byteIdx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_time_tx.sv
// Table-driven bench for uart_time_tx: a mid-bit UART monitor checks received bytes against a scoreboard queue.
module tb_uart_time_tx;

    localparam int C = 4;
`ifdef TX_SECONDS_EN
    localparam int FLEN = 10;
`else
    localparam int FLEN = 7;
`endif
    localparam int FRAME_CYC = FLEN * (1 + 10 * C);
    localparam int NVEC = 6;

    logic       clk = 1'b0;
    logic       rst_btn;
    logic       send;
    logic [7:0] hour, min, sec;
    logic       tx, busy, drop;

    int nVec = 0;
    int nMis = 0;
    logic [7:0] expQ[$];

    typedef struct {
        logic [7:0]  h;
        logic [7:0]  m;
        logic [7:0]  s;
        logic [79:0] exp;
    } vec_t;
    vec_t vecs[NVEC];

    uart_time_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_btn(rst_btn), .send(send), .hour(hour), .min(min), .sec(sec),
        .tx(tx), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // UART monitor: start detected on a negedge sample, then bit b sampled C*b + C/2 samples later.
    int         monCnt = 0;
    int         monB;
    bit         monActive = 0;
    logic [7:0] monByte = '0;
    always @(negedge clk) begin
        if (!rst_btn) begin
            monActive = 0;
        end else if (!monActive) begin
            if (tx === 1'b0) begin
                monActive = 1;
                monCnt    = 0;
            end
        end else begin
            monCnt++;
            if (monCnt >= C / 2 && (monCnt - C / 2) % C == 0) begin
                monB = (monCnt - C / 2) / C;
                if (monB == 0) begin
                    check("start_bit", {31'd0, tx}, 32'd0);
                end else if (monB <= 8) begin
                    monByte[monB-1] = tx;
                end else begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    if (expQ.size() == 0) begin
                        nVec++;
                        nMis++;
                        $display("FAIL unexpected_byte: got %02h, required none", monByte);
                    end else begin
                        check("rx_byte", {24'd0, monByte}, {24'd0, expQ.pop_front()});
                    end
                    monActive = 0;
                end
            end
        end
    end

    task automatic setVec(input int i, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s, input logic [79:0] exp);
        vecs[i].h   = h;
        vecs[i].m   = m;
        vecs[i].s   = s;
        vecs[i].exp = exp;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // Called at a negedge with busy low; returns at the first negedge after the accept edge.
    task automatic startFrame(input int i);
        hour = vecs[i].h;
        min  = vecs[i].m;
        sec  = vecs[i].s;
        send = 1'b1;
        #1 check("accept_drop", {31'd0, drop}, 32'd0);
        for (int b = 0; b < FLEN; b++)
            expQ.push_back(vecs[i].exp[(FLEN-1-b)*8 +: 8]);
        @(negedge clk);
        send = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic runFrame(output int cyc, output logic t1, output logic t2);
        cyc = 0;
        t1  = 1'bx;
        t2  = 1'bx;
        while (busy && cyc < 5000) begin
            cyc++;
            if (cyc == 1) t1 = tx;
            if (cyc == 2) t2 = tx;
            @(negedge clk);
        end
    endtask

    initial begin
        int   cyc;
        logic t1, t2;
`ifdef TX_SECONDS_EN
        setVec(0, 8'd13,  8'd7,   8'd42,  "13:07:42\r\n");
        setVec(1, 8'd0,   8'd59,  8'd0,   "00:59:00\r\n");
        setVec(2, 8'd9,   8'd30,  8'd45,  "09:30:45\r\n");
        setVec(3, 8'd120, 8'd5,   8'd99,  "??:05:99\r\n");
        setVec(4, 8'd23,  8'd100, 8'd59,  "23:??:59\r\n");
        setVec(5, 8'd24,  8'd60,  8'd255, "24:60:??\r\n");
`else
        setVec(0, 8'd13,  8'd7,   8'd42,  "13:07\r\n");
        setVec(1, 8'd0,   8'd59,  8'd42,  "00:59\r\n");
        setVec(2, 8'd120, 8'd5,   8'd0,   "??:05\r\n");
        setVec(3, 8'd24,  8'd99,  8'd7,   "24:99\r\n");
        setVec(4, 8'd99,  8'd100, 8'd0,   "99:??\r\n");
        setVec(5, 8'd255, 8'd10,  8'd1,   "??:10\r\n");
`endif
        rst_btn = 1'b0;
        send    = 1'b0;
        hour    = '0;
        min     = '0;
        sec     = '0;
        #3;
        check("reset_tx",   {31'd0, tx},   32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_drop", {31'd0, drop}, 32'd0);
        repeat (3) @(negedge clk);
        rst_btn = 1'b1;
        @(negedge clk);

        // Frame timing on the first vector, then the rest of the table.
        for (int i = 0; i < NVEC; i++) begin
            waitIdle();
            startFrame(i);
            runFrame(cyc, t1, t2);
            check("busy_cycles", cyc, FRAME_CYC);
            check("bytes_left", expQ.size(), 0);
            if (i == 0) begin
                check("tx_load_high", {31'd0, t1}, 32'd1);
                check("tx_start_low", {31'd0, t2}, 32'd0);
            end
            repeat (5) @(negedge clk);
        end

        // Inputs changed mid-frame and sends while busy.
        waitIdle();
        startFrame(0);
        repeat (2 * (1 + 10 * C)) @(negedge clk);
        hour = 8'd22;
        min  = 8'd0;
        sec  = 8'd0;
        for (int j = 0; j < 3; j++) begin
            repeat (20) @(negedge clk);
            send = 1'b1;
            #1 check("drop_on_busy", {31'd0, drop}, 32'd1);
            @(negedge clk);
            send = 1'b0;
            #1 check("drop_clear", {31'd0, drop}, 32'd0);
        end
        runFrame(cyc, t1, t2);
        check("midframe_bytes_left", expQ.size(), 0);
        repeat (60) @(negedge clk);
        check("no_extra_frame", {31'd0, busy}, 32'd0);

        // Back-to-back: second send lands on the first cycle busy is low.
        startFrame(1);
        runFrame(cyc, t1, t2);
        check("b2b_first_cycles", cyc, FRAME_CYC);
        startFrame(2);
        runFrame(cyc, t1, t2);
        check("b2b_second_cycles", cyc, FRAME_CYC);
        check("b2b_bytes_left", expQ.size(), 0);

        // Reset during the data bits of byte 3, then a clean frame.
        repeat (5) @(negedge clk);
        startFrame(0);
        repeat (3 * (1 + 10 * C) + 11) @(negedge clk);
        rst_btn = 1'b0;
        expQ.delete();
        #1;
        check("midreset_tx",   {31'd0, tx},   32'd1);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_btn = 1'b1;
        repeat (2) @(negedge clk);
        startFrame(1);
        runFrame(cyc, t1, t2);
        check("post_reset_cycles", cyc, FRAME_CYC);
        check("post_reset_bytes_left", expQ.size(), 0);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
